// File: rtl/pulse_sequencer_if.sv
// Config/status bundle between the register logic and the pulse sequencer.
// master drives config and strobes; slave is the sequencer itself.
interface pulse_sequencer_if #(
    parameter int CNT_W = 32,
    parameter int NUM_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] delay_cyc;
    logic [CNT_W-1:0] high_cyc;
    logic [CNT_W-1:0] low_cyc;
    logic [NUM_W-1:0] num_pulses;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             cfg_err;
    logic [NUM_W-1:0] pulses_sent;

    modport master (
        output start, abort, delay_cyc, high_cyc, low_cyc, num_pulses,
        input  pulse_out, busy, done, aborted, cfg_err, pulses_sent
    );

    modport slave (
        input  start, abort, delay_cyc, high_cyc, low_cyc, num_pulses,
        output pulse_out, busy, done, aborted, cfg_err, pulses_sent
    );
endinterface

// File: rtl/pulse_sequencer.sv
// Restartable pulse-train generator: delay, then N pulses of programmable
// high/low width. All status outputs and pulse_out come straight from flops.
module pulse_sequencer #(
    parameter int CNT_W = 32,
    parameter int NUM_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    pulse_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] high_q,    high_d;
    logic [CNT_W-1:0] low_q,     low_d;
    logic [NUM_W-1:0] num_q,     num_d;
    logic [NUM_W-1:0] sent_q,    sent_d;
    logic             pulse_q,   pulse_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             abrt_q,    abrt_d;
    logic             cerr_q,    cerr_d;
    logic             cfg_ok;
    logic             last_pulse;

    assign cfg_ok = (bus.high_cyc != '0) && (bus.num_pulses != '0) &&
                    ((bus.num_pulses == NUM_ONE) || (bus.low_cyc != '0));

    // sent_q < num_q always holds in HIGH, so this add never wraps
    assign last_pulse = (sent_q + NUM_ONE) == num_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        high_d  = high_q;
        low_d   = low_q;
        num_d   = num_q;
        sent_d  = sent_q;
        done_d  = 1'b0;
        abrt_d  = 1'b0;
        cerr_d  = 1'b0;

        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            abrt_d  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (cfg_ok) begin
                            high_d = bus.high_cyc;
                            low_d  = bus.low_cyc;
                            num_d  = bus.num_pulses;
                            sent_d = '0;
                            if (bus.delay_cyc != '0) begin
                                state_d = DELAY;
                                cnt_d   = bus.delay_cyc - CNT_ONE;
                            end else begin
                                state_d = HIGH;
                                cnt_d   = bus.high_cyc - CNT_ONE;
                            end
                        end else begin
                            cerr_d = 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = HIGH;
                        cnt_d   = high_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                HIGH: begin
                    if (cnt_q == '0) begin
                        sent_d = sent_q + NUM_ONE;
                        if (last_pulse) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = LOW;
                            cnt_d   = low_q - CNT_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                LOW: begin
                    if (cnt_q == '0) begin
                        state_d = HIGH;
                        cnt_d   = high_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        pulse_d = (state_d == HIGH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            num_q   <= '0;
            sent_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            high_q  <= high_d;
            low_q   <= low_d;
            num_q   <= num_d;
            sent_q  <= sent_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
            cerr_q  <= cerr_d;
        end
    end

    assign bus.pulse_out   = pulse_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = abrt_q;
    assign bus.cfg_err     = cerr_q;
    assign bus.pulses_sent = sent_q;
endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: per-cycle traces of each output are
// packed into bit vectors (bit k = cycle k after start) and compared.
module tb_pulse_sequencer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [63:0] pv, bv, dv, av, cv;

    pulse_sequencer_if #(.CNT_W(32), .NUM_W(16)) bus ();

    pulse_sequencer #(.CNT_W(32), .NUM_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input int d, input int h, input int l, input int n);
        bus.delay_cyc  = 32'(d);
        bus.high_cyc   = 32'(h);
        bus.low_cyc    = 32'(l);
        bus.num_pulses = 16'(n);
    endtask

    // Caller sits #1 after an edge (cycle 0) with start/abort already set.
    // Cycle k is sampled #1 after edge k; inputs for cycle k set afterwards.
    task automatic capture(input int n, input logic [63:0] st_m,
                           input logic [63:0] ab_m, input int h99_at,
                           input int hback_at);
        pv = '0; bv = '0; dv = '0; av = '0; cv = '0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            pv[k] = bus.pulse_out;
            bv[k] = bus.busy;
            dv[k] = bus.done;
            av[k] = bus.aborted;
            cv[k] = bus.cfg_err;
            bus.start = st_m[k];
            bus.abort = ab_m[k];
            if (k == h99_at)   bus.high_cyc = 32'd99;
            if (k == hback_at) bus.high_cyc = 32'd2;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cfg(0, 0, 0, 0);
        idle_cycles(2);
        check("reset_outs",
              {58'd0, bus.pulse_out, bus.busy, bus.done, bus.aborted,
               bus.cfg_err, (bus.pulses_sent != 16'd0)}, 64'd0);
        rst = 1'b0;
        idle_cycles(2);

        // basic train D=3 H=2 L=4 N=3
        cfg(3, 2, 4, 3);
        bus.start = 1'b1;
        capture(30, 64'd0, 64'd0, 0, 0);
        check("basic_pulse", pv, 64'h30C30);
        check("basic_busy",  bv, 64'h3FFFE);
        check("basic_done",  dv, 64'h40000);
        check("basic_abrt",  av, 64'd0);
        check("basic_cerr",  cv, 64'd0);
        check("basic_sent",  64'(bus.pulses_sent), 64'd3);

        // zero delay, single pulse
        cfg(0, 1, 0, 1);
        bus.start = 1'b1;
        capture(6, 64'd0, 64'd0, 0, 0);
        check("zd_pulse", pv, 64'h2);
        check("zd_busy",  bv, 64'h2);
        check("zd_done",  dv, 64'h4);
        check("zd_cerr",  cv, 64'd0);
        check("zd_sent",  64'(bus.pulses_sent), 64'd1);

        // invalid configs
        cfg(2, 0, 3, 2);
        bus.start = 1'b1;
        capture(4, 64'd0, 64'd0, 0, 0);
        check("bad_h0_cerr", cv, 64'h2);
        check("bad_h0_busy", bv | pv, 64'd0);
        cfg(2, 3, 3, 0);
        bus.start = 1'b1;
        capture(4, 64'd0, 64'd0, 0, 0);
        check("bad_n0_cerr", cv, 64'h2);
        check("bad_n0_busy", bv | pv, 64'd0);
        cfg(2, 3, 0, 2);
        bus.start = 1'b1;
        capture(4, 64'd0, 64'd0, 0, 0);
        check("bad_l0_cerr", cv, 64'h2);
        check("bad_l0_busy", bv | pv, 64'd0);
        check("bad_sent",    64'(bus.pulses_sent), 64'd1);

        // start+abort together in IDLE: both ignored
        cfg(0, 2, 2, 2);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        capture(4, 64'd0, 64'd0, 0, 0);
        check("sa_idle_busy", bv | pv, 64'd0);
        check("sa_idle_abrt", av | dv, 64'd0);

        // abort during second pulse (abort asserted in cycle 25)
        cfg(0, 10, 10, 5);
        bus.start = 1'b1;
        capture(40, 64'd0, 64'd1 << 25, 0, 0);
        check("ab_pulse", pv, 64'h3E007FE);
        check("ab_busy",  bv, 64'h3FFFFFE);
        check("ab_abrt",  av, 64'h4000000);
        check("ab_done",  dv, 64'd0);
        check("ab_sent",  64'(bus.pulses_sent), 64'd1);

        // restart while busy, config churn, back-to-back start on done
        cfg(3, 2, 4, 3);
        bus.start = 1'b1;
        capture(40, (64'd1 << 8) | (64'd1 << 18), 64'd0, 5, 12);
        check("rs_pulse", pv, 64'h30C30 | (64'h30C30 << 18));
        check("rs_busy",  bv, 64'h3FFFE | (64'h3FFFE << 18));
        check("rs_done",  dv, (64'd1 << 18) | (64'd1 << 36));
        check("rs_cerr",  cv | av, 64'd0);

        // async reset mid-HIGH of the second pulse
        cfg(0, 10, 10, 5);
        bus.start = 1'b1;
        capture(25, 64'd0, 64'd0, 0, 0);
        check("ar_pre", {62'd0, bus.pulse_out, bus.busy} |
              (64'(bus.pulses_sent) << 2), 64'h7);
        #2 rst = 1'b1;
        #1;
        check("ar_pulse", 64'(bus.pulse_out), 64'd0);
        check("ar_busy",  64'(bus.busy), 64'd0);
        check("ar_sent",  64'(bus.pulses_sent), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        capture(5, 64'd0, 64'd0, 0, 0);
        check("ar_strobes", dv | av | cv | pv | bv, 64'd0);
        cfg(3, 2, 4, 3);
        bus.start = 1'b1;
        capture(30, 64'd0, 64'd0, 0, 0);
        check("ar_again_pulse", pv, 64'h30C30);
        check("ar_again_done",  dv, 64'h40000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Programmable pulse-train controller that sequences a single pulse output.
- Configured by the MicroBlaze-side register logic through level config inputs and a start strobe.
- Produces an initial delay, then N pulses with programmable high and low widths, with busy/done/abort status for software polling.
- Replaces free-running single-shot compare timing with a controlled, restartable sequence.

Parameters:
- CNT_W, 32, width of delay/high/low cycle counts.
- NUM_W, 16, width of pulse count and pulses_sent.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- abort  in  1  one-cycle request to terminate the sequence immediately.
- delay_cyc  in  CNT_W  cycles from start acceptance to the first rising edge of pulse_out.
- high_cyc  in  CNT_W  high width of each pulse, in cycles.
- low_cyc  in  CNT_W  low gap between consecutive pulses, in cycles.
- num_pulses  in  NUM_W  number of pulses in the train.
- pulse_out  out  1  registered pulse output.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-cycle strobe on normal completion.
- aborted  out  1  one-cycle strobe when abort terminates an active sequence.
- cfg_err  out  1  one-cycle strobe when start is rejected for an invalid config.
- pulses_sent  out  NUM_W  number of completed high phases in the current or last sequence.

Behaviour:
- Reset (async, rst=1): state IDLE; pulse_out, busy, done, aborted, cfg_err =0; pulses_sent=0; internal counters=0.
- FSM states: IDLE, DELAY, HIGH, LOW.
- Config validity: high_cyc>=1, num_pulses>=1, and low_cyc>=1 whenever num_pulses>1. Otherwise the config is invalid.
- Start handling in IDLE:
  - Invalid config: cfg_err=1 for the next cycle; remain IDLE; pulses_sent unchanged.
  - Valid config: latch all config inputs into shadow registers at edge t. Later input changes have no effect until the next accepted start.
  - Set pulses_sent=0 and busy=1 from cycle t+1.
  - Next state is DELAY if delay_cyc>0, else HIGH.
- DELAY: down-counter loaded with delay_cyc-1; pulse_out=0. When the counter reaches 0, go to HIGH. Duration is exactly delay_cyc cycles.
- HIGH: pulse_out=1 for exactly high_cyc cycles. On the last high cycle, pulses_sent increments at that edge.
  - If this was pulse num_pulses: go to IDLE; next cycle pulse_out=0, busy=0, done=1 (single cycle).
  - Otherwise go to LOW.
- LOW: pulse_out=0 for exactly low_cyc cycles, then go to HIGH. There is no trailing LOW after the final pulse.
- Timing reference, start accepted at edge t:
  - pulse_out rises at t+1+D.
  - Pulse k (1-based) occupies cycles t+1+D+(k-1)(H+L) to t+D+kH+(k-1)L.
  - done is high at cycle t+1+D+NH+(N-1)L.
- pulse_out comes directly from a flop: no glitches and no combinational path from inputs.
- start while busy: ignored, no error flag, sequence unaffected.
- abort while busy: next edge goes to IDLE, with pulse_out=0, busy=0, aborted=1 for one cycle, done=0; pulses_sent holds its value.
- abort in IDLE: no effect, aborted stays 0.
- start and abort in the same cycle: abort has priority. In IDLE both are ignored; while busy it behaves as abort.
- done and start in the same cycle: start is accepted, because the state is already IDLE on that cycle.
- Counters compare against value-1, so there is no overflow. Maximum values (2^CNT_W-1) must time correctly without wrap.
- pulses_sent saturates by construction, since it never exceeds num_pulses.
- Reset mid-sequence: outputs go to reset values immediately (async) and no strobe is produced.

Test Plan:
- Basic train: D=3, H=2, L=4, N=3, start at cycle 0 -> pulse_out high cycles 4-5, 10-11, 16-17; done=1 at cycle 18; busy high cycles 1-17; pulses_sent=3.
- Zero delay, single pulse: D=0, H=1, L=0, N=1 -> pulse_out high only at cycle 1; done at cycle 2; cfg_err stays 0.
- Invalid configs: H=0; then N=0; then L=0 with N=2 -> each gives cfg_err one cycle after start, busy stays 0, pulse_out stays 0.
- Abort: D=0, H=10, L=10, N=5, abort during the second pulse's high phase -> pulse_out=0 and busy=0 next cycle, aborted one cycle, done never asserted, pulses_sent=1.
- Start while busy / config change: re-pulse start and change high_cyc to 99 mid-train -> timing unchanged from the latched values; back-to-back start in the done cycle is accepted.
- Async reset: assert rst between clock edges mid-HIGH -> pulse_out, busy, pulses_sent go to 0 before the next edge; no done or aborted strobe; a new start after release works normally.
